mux_gate_sequencer: RTL and testbench

//  Shares one 2:1 mux cell between N requesters, evaluating any 2-input logic gate on it.

---
 rtl/mux_gate_pkg.sv | 26 ++
 rtl/mux2_cell.sv | 11 +
 rtl/mux_gate_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mux_gate_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_gate_pkg.sv
// Shared definitions for the mux-based gate sequencer: opcodes, FSM states
// and the pass-count helper.
package mux_gate_pkg;

   localparam logic [2:0] OP_BUF  = 3'b000;
   localparam logic [2:0] OP_NOT  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_NAND = 3'b100;
   localparam logic [2:0] OP_NOR  = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_XNOR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS1 = 2'd1,
      ST_PASS2 = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Every op with the top opcode bit set needs a second mux pass.
   function automatic logic two_pass(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/mux2_cell.sv
// Single shared 2:1 mux cell: y = s ? d1 : d0.
module mux2_cell (
   input  logic d0,
   input  logic d1,
   input  logic s,
   output logic y
);

   assign y = s ? d1 : d0;

endmodule

// File: rtl/mux_gate_sequencer.sv
// Round-robin front end that evaluates any 2-input gate on one shared 2:1 mux
// cell in one or two passes and returns a tagged one-cycle response.
//
// state | meaning
// IDLE  | waiting for a request; arbiter grant drives req_ready
// PASS1 | first mux evaluation, result captured in t
// PASS2 | second mux evaluation using t (NAND/NOR/XOR/XNOR only)
// DONE  | one-cycle rsp_valid pulse to the granted requester
module mux_gate_sequencer
   import mux_gate_pkg::*;
#(
   parameter int N    = 4,
   parameter int IDW  = $clog2(N),
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      req_valid,
   input  logic [3*N-1:0]    req_op,
   input  logic [N-1:0]      req_a,
   input  logic [N-1:0]      req_b,
   output logic [N-1:0]      req_ready,
   output logic [N-1:0]      rsp_valid,
   output logic              rsp_y,
   output logic [IDW-1:0]    rsp_id,
   output logic              busy,
   output logic [CNTW-1:0]   mux_passes
);

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   g_q;
   logic [2:0]       op_q;
   logic             a_q;
   logic             b_q;
   logic             t_q;

   logic             grant_found;
   logic [IDW-1:0]   grant_idx;
   logic [2:0]       sel_op;
   logic             sel_a;
   logic             sel_b;

   logic             mux_d0;
   logic             mux_d1;
   logic             mux_s;
   logic             mux_y;

   // Search starts just above rr_ptr so the last-served requester is checked last.
   always_comb begin
      logic [IDW-1:0] cand;
      cand        = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IDW'((int'(rr_ptr) + k) % N);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_op = '0;
      sel_a  = 1'b0;
      sel_b  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (IDW'(i) == grant_idx) begin
            sel_op = req_op[3*i +: 3];
            sel_a  = req_a[i];
            sel_b  = req_b[i];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && state == ST_IDLE && grant_found)
         req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      {mux_d0, mux_d1, mux_s} = 3'b000;
      case (state)
         ST_PASS1: begin
            case (op_q)
               OP_BUF:          {mux_d0, mux_d1, mux_s} = {1'b0, 1'b1, a_q};
               OP_NOT:          {mux_d0, mux_d1, mux_s} = {1'b1, 1'b0, a_q};
               OP_AND, OP_NAND: {mux_d0, mux_d1, mux_s} = {1'b0, b_q,  a_q};
               OP_OR,  OP_NOR:  {mux_d0, mux_d1, mux_s} = {b_q,  1'b1, a_q};
               default:         {mux_d0, mux_d1, mux_s} = {1'b1, 1'b0, b_q};
            endcase
         end
         ST_PASS2: begin
            case (op_q)
               OP_XOR:  {mux_d0, mux_d1, mux_s} = {b_q,  t_q,  a_q};
               OP_XNOR: {mux_d0, mux_d1, mux_s} = {t_q,  b_q,  a_q};
               default: {mux_d0, mux_d1, mux_s} = {1'b1, 1'b0, t_q};
            endcase
         end
         default: {mux_d0, mux_d1, mux_s} = 3'b000;
      endcase
   end

   mux2_cell u_mux (
      .d0 (mux_d0),
      .d1 (mux_d1),
      .s  (mux_s),
      .y  (mux_y)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         rr_ptr     <= IDW'(N - 1);
         g_q        <= '0;
         op_q       <= '0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         t_q        <= 1'b0;
         rsp_valid  <= '0;
         rsp_y      <= 1'b0;
         rsp_id     <= '0;
         busy       <= 1'b0;
         mux_passes <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               rsp_valid <= '0;
               if (grant_found) begin
                  op_q   <= sel_op;
                  a_q    <= sel_a;
                  b_q    <= sel_b;
                  g_q    <= grant_idx;
                  rr_ptr <= grant_idx;
                  busy   <= 1'b1;
                  state  <= ST_PASS1;
               end
            end
            ST_PASS1: begin
               t_q <= mux_y;
               if (mux_passes != '1)
                  mux_passes <= mux_passes + 1'b1;
               if (two_pass(op_q)) begin
                  state <= ST_PASS2;
               end else begin
                  rsp_valid        <= '0;
                  rsp_valid[g_q]   <= 1'b1;
                  rsp_y            <= mux_y;
                  rsp_id           <= g_q;
                  state            <= ST_DONE;
               end
            end
            ST_PASS2: begin
               if (mux_passes != '1)
                  mux_passes <= mux_passes + 1'b1;
               rsp_valid      <= '0;
               rsp_valid[g_q] <= 1'b1;
               rsp_y          <= mux_y;
               rsp_id         <= g_q;
               state          <= ST_DONE;
            end
            default: begin
               rsp_valid <= '0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// Directed bench for mux_gate_sequencer: gate truth table, latency, round-robin
// order, mid-op reset, operand latching and counter saturation (CNTW=4 copy).
module tb_mux_gate_sequencer;

   localparam int N   = 4;
   localparam int IDW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [3*N-1:0]  req_op;
   logic [N-1:0]    req_a;
   logic [N-1:0]    req_b;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic            rsp_y;
   logic [IDW-1:0]  rsp_id;
   logic            busy;
   logic [15:0]     mux_passes;

   logic [N-1:0]    req_ready_s;
   logic [N-1:0]    rsp_valid_s;
   logic            rsp_y_s;
   logic [IDW-1:0]  rsp_id_s;
   logic            busy_s;
   logic [3:0]      mux_passes_s;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_passes = 0;

   always #5 clk = ~clk;

   mux_gate_sequencer #(.N(N), .IDW(IDW), .CNTW(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_y(rsp_y), .rsp_id(rsp_id), .busy(busy), .mux_passes(mux_passes)
   );

   // Narrow-counter copy on the same stimulus, used for saturation.
   mux_gate_sequencer #(.N(N), .IDW(IDW), .CNTW(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready_s), .rsp_valid(rsp_valid_s),
      .rsp_y(rsp_y_s), .rsp_id(rsp_id_s), .busy(busy_s), .mux_passes(mux_passes_s)
   );

   typedef struct {
      int         r;
      logic [2:0] op;
      logic       a;
      logic       b;
      logic       y;
   } vec_t;

   vec_t vecs[32];

   function automatic logic gate_model(input logic [2:0] op, input logic a, input logic b);
      case (op)
         3'b000:  return a;
         3'b001:  return ~a;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return ~(a & b);
         3'b101:  return ~(a | b);
         3'b110:  return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   function automatic logic [N-1:0] onehot(input int r);
      logic [N-1:0] v;
      v = '0;
      v[r] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_counters();
      chk("mux_passes", 32'(mux_passes), 32'(exp_passes));
      chk("mux_passes_sat", 32'(mux_passes_s), 32'(exp_passes > 15 ? 15 : exp_passes));
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after DONE.
   task automatic do_op(input int r, input logic [2:0] op, input logic a, input logic b,
                        input logic y, input bit scramble);
      bit two;
      two = op[2];
      req_valid = '0;
      req_valid[r] = 1'b1;
      req_op[3*r +: 3] = op;
      req_a[r] = a;
      req_b[r] = b;
      #1;
      chk("accept_ready", 32'(req_ready), 32'(onehot(r)));
      chk("accept_busy", 32'(busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
      req_valid[r] = 1'b0;
      if (scramble) begin
         req_op = ~req_op; req_a = ~req_a; req_b = ~req_b;
      end
      #1;
      chk("pass1_rsp", 32'(rsp_valid), 32'd0);
      chk("pass1_busy", 32'(busy), 32'd1);
      if (two) begin
         @(negedge clk);
         if (scramble) begin
            req_op = ~req_op; req_a = ~req_a; req_b = ~req_b;
         end
         #1;
         chk("pass2_rsp", 32'(rsp_valid), 32'd0);
      end
      @(negedge clk);
      chk("done_rsp_valid", 32'(rsp_valid), 32'(onehot(r)));
      chk("done_rsp_y", 32'(rsp_y), 32'(y));
      chk("done_rsp_id", 32'(rsp_id), 32'(r));
      chk("done_no_ready", 32'(req_ready), 32'd0);
      exp_passes += two ? 2 : 1;
      chk_counters();
      @(negedge clk);
      chk("idle_rsp", 32'(rsp_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_y", 32'(rsp_y), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_passes", 32'(mux_passes), 32'd0);
      exp_passes = 0;
      rst_n = 1'b1;
   endtask

   initial begin
      int cyc;
      int exp_g;
      int k;

      for (int op = 0; op < 8; op++)
         for (int ab = 0; ab < 4; ab++) begin
            k = op * 4 + ab;
            vecs[k].r  = 2;
            vecs[k].op = 3'(op);
            vecs[k].a  = ab[1];
            vecs[k].b  = ab[0];
            vecs[k].y  = gate_model(3'(op), ab[1], ab[0]);
         end

      @(negedge clk);
      do_reset();

      // Single-pass and two-pass latency, hand-computed results.
      do_op(0, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
      do_op(1, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0);
      do_op(1, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0);
      do_op(1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1);
      do_op(3, 3'b110, 1'b0, 1'b1, 1'b1, 1'b1);
      do_op(0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 32; i++)
         do_op(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, 1'b0);
      chk("sat_reached", 32'(mux_passes_s), 32'd15);

      // Round robin with all requesters held valid: grants 0,1,2,3,0.
      do_reset();
      @(negedge clk);
      req_op = {3'b000, 3'b000, 3'b000, 3'b000};
      req_a = 4'b0101;
      req_valid = 4'b1111;
      #1;
      for (int n = 0; n < 5; n++) begin
         exp_g = n % N;
         cyc = 0;
         while (req_ready == '0 && cyc < 20) begin
            @(negedge clk); #1; cyc++;
         end
         chk("rr_grant", 32'(req_ready), 32'(onehot(exp_g)));
         exp_passes++;
         @(negedge clk); #1;
         cyc = 0;
         while (rsp_valid == '0 && cyc < 20) begin
            @(negedge clk); #1; cyc++;
         end
         chk("rr_rsp_valid", 32'(rsp_valid), 32'(onehot(exp_g)));
         chk("rr_rsp_y", 32'(rsp_y), 32'(req_a[exp_g]));
         chk("rr_ready_vs_rsp", 32'(req_ready & rsp_valid), 32'd0);
         @(negedge clk); #1;
      end
      req_valid = '0;
      @(negedge clk);
      chk("rr_idle_busy", 32'(busy), 32'd0);
      chk_counters();

      // Reset during PASS1 of a NAND: no response, reset values, rr_ptr back to N-1.
      do_reset();
      @(negedge clk);
      req_valid = 4'b0001;
      req_op[2:0] = 3'b100;
      req_a[0] = 1'b1;
      req_b[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      chk("mid_busy_pass1", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_y", 32'(rsp_y), 32'd0);
      chk("mid_rst_id", 32'(rsp_id), 32'd0);
      chk("mid_rst_passes", 32'(mux_passes), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_no_late_rsp", 32'(rsp_valid), 32'd0);
      req_valid = 4'b1000;
      #1;
      chk("post_rst_req3", 32'(req_ready), 32'b1000);
      req_valid = 4'b1001;
      #1;
      chk("post_rst_req0_first", 32'(req_ready), 32'b0001);
      req_valid = '0;
      @(negedge clk);
      chk("post_rst_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
